urv_divide_iter: RTL and testbench
==================================

Name: urv_divide_iter

Overview:
- Parametrised multi-cycle integer divider for the uRV execute stage; implements RV32M DIV/DIVU/REM/REMU.
- Radix is selectable: 1, 2 or 4 quotient bits per cycle.
- Stalls the pipeline through x_stall_req_o while computing, and presents the result on x_rd_o for the writeback register.
- Handles the RISC-V divide-by-zero and signed-overflow cases in a fast path, and supports kill at any point.

Parameters:
XLEN, 32, operand/result width; must be a multiple of BITS_PER_CYCLE.
BITS_PER_CYCLE, 1, quotient bits retired per iteration cycle; legal values 1, 2, 4.

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous reset, active-high
x_stall_i  input  1  execute stage stall (may include this block's own request)
x_kill_i  input  1  flush current execute instruction
x_stall_req_o  output  1  stall request to pipeline control
d_valid_i  input  1  decode instruction valid
d_is_divide_i  input  1  instruction is DIV/DIVU/REM/REMU
d_fun_i  input  3  funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU
d_rs1_i  input  XLEN  dividend
d_rs2_i  input  XLEN  divisor
x_rd_o  output  XLEN  result (quotient or remainder per d_fun_i)
x_busy_o  output  1  high in any state other than IDLE

Behaviour:
- One clock, clk_i. Reset is synchronous and active-high on rst_i.
- On reset: state IDLE, x_busy_o=0, x_stall_req_o=0, x_rd_o=0, internal registers cleared.
- States:
  - IDLE: start condition is d_valid_i & d_is_divide_i & !x_kill_i. On start, latch the function and the operand signs, then:
    - divisor==0 -> DONE;
    - signed op with rs1==1<<(XLEN-1) and rs2==all-ones -> DONE;
    - otherwise latch |rs1|, |rs2| (magnitudes for signed ops, raw values for unsigned ops) -> BUSY with iteration counter = XLEN/BITS_PER_CYCLE-1.
  - BUSY: each cycle performs BITS_PER_CYCLE restoring shift-subtract steps on a {remainder, quotient} register. Counter decrements; at 0 -> FIX. Advances regardless of x_stall_i.
  - FIX: apply sign correction. Quotient is negated if sign(rs1)!=sign(rs2) for DIV. Remainder takes the sign of rs1 for REM. Register the selected value into x_rd_o -> DONE.
  - DONE: hold x_rd_o. On a cycle with !x_stall_i -> IDLE. Never starts a new operation from DONE; the instruction at the inputs in DONE is the one just completed.
- x_stall_req_o (combinational):
  - high in IDLE when the start condition holds;
  - high in BUSY and FIX;
  - low in DONE;
  - forced low whenever x_kill_i=1.
- Stall length:
  - normal path: XLEN/BITS_PER_CYCLE+2 cycles (32/34 at default);
  - fast path: 1 cycle.
- Fast-path results, registered on the IDLE->DONE edge:
  - divide by zero: quotient = all-ones, remainder = rs1 (both signed and unsigned);
  - overflow: quotient = rs1, remainder = 0.
- Kill: x_kill_i in any state -> IDLE next edge; no result is presented; x_rd_o keeps its last value.
- Inputs d_rs1_i, d_rs2_i and d_fun_i need not be stable after the start cycle; everything required is latched.
- Back-to-back divides: the second divide starts from IDLE in the cycle after DONE exits. No lost or duplicated operation.
- Reset mid-operation: immediate return to IDLE; x_stall_req_o low in the following cycle.
- All arithmetic is XLEN+1 wide internally for the trial subtract. Magnitude of the most-negative value is correct as an unsigned XLEN value.

Test Plan:
- XLEN=32, BITS_PER_CYCLE=1: DIV rs1=-7 (0xFFFFFFF9), rs2=2 -> x_stall_req_o high exactly 34 cycles, then x_rd_o=0xFFFFFFFD (-3); REM same operands -> 0xFFFFFFFF (-1).
- DIVU 100/7 -> 14; REMU 100/7 -> 2. Repeat with BITS_PER_CYCLE=4 -> same results, stall exactly 10 cycles.
- DIV 5/0 -> 0xFFFFFFFF after 1 stall cycle; REMU 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; each with 1 stall cycle.
- Assert x_kill_i in the 10th BUSY cycle -> x_stall_req_o low that cycle, x_busy_o low next cycle. A following DIVU 9/3 -> 3 with full latency.
- Hold x_stall_i high for 5 cycles after DONE -> x_rd_o stable, no restart. Then two consecutive DIVU ops (0xFFFFFFFF/1, then 10/3) -> 0xFFFFFFFF then 3; no overlap.
- Assert rst_i mid-BUSY -> next cycle x_busy_o=0, x_stall_req_o=0, x_rd_o=0.

Source files
------------

// File: rtl/urv_divide_iter_if.sv
// ---------------------------------------------------------------------------
// urv_divide_iter_if
//   Groups the execute-stage divider signals into one bundle.
//   Signal names carry their direction as seen from the divider.
//   x_stall_i      pipeline stall (may include the divider's own request)
//   x_kill_i       flush of the instruction in execute
//   x_stall_req_o  stall request from the divider
//   d_valid_i      decode instruction valid
//   d_is_divide_i  instruction is DIV/DIVU/REM/REMU
//   d_fun_i        funct3 (100 DIV, 101 DIVU, 110 REM, 111 REMU)
//   d_rs1_i        dividend
//   d_rs2_i        divisor
//   x_rd_o         result for writeback
//   x_busy_o       divider not idle
//   Modports: slave = divider, master = pipeline / testbench.
// ---------------------------------------------------------------------------
interface urv_divide_iter_if #(
    parameter int XLEN = 32
);
    logic            x_stall_i;
    logic            x_kill_i;
    logic            x_stall_req_o;
    logic            d_valid_i;
    logic            d_is_divide_i;
    logic [2:0]      d_fun_i;
    logic [XLEN-1:0] d_rs1_i;
    logic [XLEN-1:0] d_rs2_i;
    logic [XLEN-1:0] x_rd_o;
    logic            x_busy_o;

    modport slave (
        input  x_stall_i, x_kill_i, d_valid_i, d_is_divide_i, d_fun_i, d_rs1_i, d_rs2_i,
        output x_stall_req_o, x_rd_o, x_busy_o
    );

    modport master (
        output x_stall_i, x_kill_i, d_valid_i, d_is_divide_i, d_fun_i, d_rs1_i, d_rs2_i,
        input  x_stall_req_o, x_rd_o, x_busy_o
    );
endinterface

// File: rtl/urv_divide_iter.sv
// ---------------------------------------------------------------------------
// urv_divide_iter
//   Multi-cycle RV32M divider (DIV/DIVU/REM/REMU) for the execute stage.
//   Restoring division on magnitudes, BITS_PER_CYCLE quotient bits per
//   cycle, sign fix-up in a final cycle. Divide-by-zero and signed overflow
//   finish in a single cycle.
//   Ports:
//     clk_i  clock
//     rst_i  synchronous reset, active high
//     dif    divider bus (slave modport of urv_divide_iter_if)
// ---------------------------------------------------------------------------
module urv_divide_iter #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    urv_divide_iter_if.slave    dif
);
    localparam int ITER = XLEN / BITS_PER_CYCLE;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX, S_DONE} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            is_rem_q, is_rem_d;
    logic            rs1_neg_q, rs1_neg_d;   // remainder must be negated
    logic            quo_neg_q, quo_neg_d;   // quotient must be negated
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;           // holds dividend bits, shifted out as quotient fills in
    logic [XLEN-1:0] div_q, div_d;
    logic [XLEN-1:0] rd_q, rd_d;

    logic            start;
    logic            is_signed;
    logic [XLEN-1:0] rs1_abs, rs2_abs;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] rem_s [BITS_PER_CYCLE+1];
    logic [XLEN-1:0] quo_s [BITS_PER_CYCLE+1];

    assign start     = dif.d_valid_i & dif.d_is_divide_i & ~dif.x_kill_i;
    assign is_signed = ~dif.d_fun_i[0];
    assign rs1_abs   = (is_signed & dif.d_rs1_i[XLEN-1]) ? -dif.d_rs1_i : dif.d_rs1_i;
    assign rs2_abs   = (is_signed & dif.d_rs2_i[XLEN-1]) ? -dif.d_rs2_i : dif.d_rs2_i;

    // ---- state / datapath registers ----
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            is_rem_q  <= 1'b0;
            rs1_neg_q <= 1'b0;
            quo_neg_q <= 1'b0;
            rem_q     <= '0;
            quo_q     <= '0;
            div_q     <= '0;
            rd_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_rem_q  <= is_rem_d;
            rs1_neg_q <= rs1_neg_d;
            quo_neg_q <= quo_neg_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            div_q     <= div_d;
            rd_q      <= rd_d;
        end
    end

    // ---- next state ----
    always_comb begin
        state_d = state_q;
        if (dif.x_kill_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (dif.d_rs2_i == '0)
                            state_d = S_DONE;
                        else if (is_signed && dif.d_rs1_i == {1'b1, {(XLEN-1){1'b0}}} &&
                                 dif.d_rs2_i == '1)
                            state_d = S_DONE;
                        else
                            state_d = S_BUSY;
                    end
                end
                S_BUSY:  if (cnt_q == '0) state_d = S_FIX;
                S_FIX:   state_d = S_DONE;
                S_DONE:  if (!dif.x_stall_i) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ---- datapath next values ----
    always_comb begin
        cnt_d     = cnt_q;
        is_rem_d  = is_rem_q;
        rs1_neg_d = rs1_neg_q;
        quo_neg_d = quo_neg_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        div_d     = div_q;
        rd_d      = rd_q;
        trial     = '0;

        // Restoring steps: shift the next dividend bit into the partial
        // remainder, keep the difference if it did not borrow.
        rem_s[0] = rem_q;
        quo_s[0] = quo_q;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            trial = {rem_s[i], quo_s[i][XLEN-1]} - {1'b0, div_q};
            if (trial[XLEN]) begin
                rem_s[i+1] = {rem_s[i][XLEN-2:0], quo_s[i][XLEN-1]};
                quo_s[i+1] = {quo_s[i][XLEN-2:0], 1'b0};
            end else begin
                rem_s[i+1] = trial[XLEN-1:0];
                quo_s[i+1] = {quo_s[i][XLEN-2:0], 1'b1};
            end
        end

        // A kill must leave rd untouched, so nothing updates under kill.
        if (!dif.x_kill_i) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        is_rem_d  = dif.d_fun_i[1];
                        rs1_neg_d = is_signed & dif.d_rs1_i[XLEN-1];
                        quo_neg_d = is_signed & (dif.d_rs1_i[XLEN-1] ^ dif.d_rs2_i[XLEN-1]);
                        if (dif.d_rs2_i == '0) begin
                            rd_d = dif.d_fun_i[1] ? dif.d_rs1_i : '1;
                        end else if (is_signed && dif.d_rs1_i == {1'b1, {(XLEN-1){1'b0}}} &&
                                     dif.d_rs2_i == '1) begin
                            rd_d = dif.d_fun_i[1] ? '0 : dif.d_rs1_i;
                        end else begin
                            rem_d = '0;
                            quo_d = rs1_abs;
                            div_d = rs2_abs;
                            cnt_d = CW'(ITER - 1);
                        end
                    end
                end
                S_BUSY: begin
                    rem_d = rem_s[BITS_PER_CYCLE];
                    quo_d = quo_s[BITS_PER_CYCLE];
                    cnt_d = cnt_q - 1'b1;
                end
                S_FIX: begin
                    if (is_rem_q)
                        rd_d = rs1_neg_q ? -rem_q : rem_q;
                    else
                        rd_d = quo_neg_q ? -quo_q : quo_q;
                end
                default: ;
            endcase
        end
    end

    // ---- outputs ----
    always_comb begin
        dif.x_stall_req_o = 1'b0;
        if (!dif.x_kill_i) begin
            case (state_q)
                S_IDLE:       dif.x_stall_req_o = start;
                S_BUSY, S_FIX: dif.x_stall_req_o = 1'b1;
                default:      dif.x_stall_req_o = 1'b0;
            endcase
        end
        dif.x_busy_o = (state_q != S_IDLE);
        dif.x_rd_o   = rd_q;
    end
endmodule

// File: tb/tb_urv_divide_iter.sv
// ---------------------------------------------------------------------------
// tb_urv_divide_iter
//   Directed vectors against two divider instances (1 and 4 bits/cycle).
//   Stimulus pushes the expected result into a per-instance queue; a monitor
//   per instance pops and compares whenever the divider enters DONE.
// ---------------------------------------------------------------------------
module tb_urv_divide_iter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst    = 1'b1;
    logic        sel    = 1'b0;   // 0: radix-2 instance, 1: radix-16 instance
    logic        d_valid = 1'b0;
    logic        kill   = 1'b0;
    logic        hold   = 1'b0;
    logic [2:0]  fun    = 3'b000;
    logic [31:0] rs1    = '0;
    logic [31:0] rs2    = '0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] q1[$];
    logic [31:0] q4[$];

    urv_divide_iter_if #(.XLEN(32)) if1 ();
    urv_divide_iter_if #(.XLEN(32)) if4 ();

    assign if1.x_stall_i     = if1.x_stall_req_o | hold;
    assign if1.x_kill_i      = kill;
    assign if1.d_valid_i     = d_valid & ~sel;
    assign if1.d_is_divide_i = 1'b1;
    assign if1.d_fun_i       = fun;
    assign if1.d_rs1_i       = rs1;
    assign if1.d_rs2_i       = rs2;

    assign if4.x_stall_i     = if4.x_stall_req_o | hold;
    assign if4.x_kill_i      = kill;
    assign if4.d_valid_i     = d_valid & sel;
    assign if4.d_is_divide_i = 1'b1;
    assign if4.d_fun_i       = fun;
    assign if4.d_rs1_i       = rs1;
    assign if4.d_rs2_i       = rs2;

    urv_divide_iter #(.XLEN(32), .BITS_PER_CYCLE(1)) u_div1 (
        .clk_i(clk), .rst_i(rst), .dif(if1.slave));
    urv_divide_iter #(.XLEN(32), .BITS_PER_CYCLE(4)) u_div4 (
        .clk_i(clk), .rst_i(rst), .dif(if4.slave));

    logic        s_busy, s_stall;
    logic [31:0] s_rd;
    assign s_busy  = sel ? if4.x_busy_o      : if1.x_busy_o;
    assign s_stall = sel ? if4.x_stall_req_o : if1.x_stall_req_o;
    assign s_rd    = sel ? if4.x_rd_o        : if1.x_rd_o;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---- monitors: compare on every entry into DONE ----
    logic done1_prev = 1'b0, done4_prev = 1'b0;
    always @(negedge clk) begin
        logic d1, d4;
        d1 = if1.x_busy_o & ~if1.x_stall_req_o & ~kill & ~rst;
        d4 = if4.x_busy_o & ~if4.x_stall_req_o & ~kill & ~rst;
        if (d1 && !done1_prev) begin
            if (q1.size() == 0) chk("r1_unexpected", if1.x_rd_o, 32'hxxxx_xxxx);
            else                chk("r1_result", if1.x_rd_o, q1.pop_front());
        end
        if (d4 && !done4_prev) begin
            if (q4.size() == 0) chk("r4_unexpected", if4.x_rd_o, 32'hxxxx_xxxx);
            else                chk("r4_result", if4.x_rd_o, q4.pop_front());
        end
        done1_prev <= d1;
        done4_prev <= d4;
    end

    // Issue one divide on the selected instance; returns while it sits in DONE.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int exp_stall);
        int cnt   = 0;
        int guard = 0;
        fun = f; rs1 = a; rs2 = b; d_valid = 1'b1;
        if (sel) q4.push_back(exp); else q1.push_back(exp);
        #1;
        // leave a previous DONE first
        while (s_busy && !s_stall && guard < 200) begin @(negedge clk); #1; guard++; end
        while (!(s_busy && !s_stall) && guard < 200) begin
            if (s_stall) cnt++;
            @(negedge clk); #1; guard++;
        end
        d_valid = 1'b0;
        if (guard >= 200) chk("issue_timeout", 32'(guard), 32'd0);
        chk("stall_len", 32'(cnt), 32'(exp_stall));
    endtask

    initial begin
        int n;
        int guard;
        // ---- reset state ----
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy",  {31'd0, if1.x_busy_o},      32'd0);
        chk("rst_stall", {31'd0, if1.x_stall_req_o}, 32'd0);
        chk("rst_rd",    if1.x_rd_o,                 32'd0);
        rst = 1'b0;
        @(negedge clk); #1;

        // ---- radix-2 instance ----
        issue(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);  // DIV -7/2
        issue(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);  // REM -7/2
        issue(3'b101, 32'd100, 32'd7, 32'd14, 34);               // DIVU
        issue(3'b111, 32'd100, 32'd7, 32'd2, 34);                // REMU
        issue(3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);           // DIV /0
        issue(3'b111, 32'd5, 32'd0, 32'd5, 1);                   // REMU /0

        // kill in the 10th BUSY cycle
        @(negedge clk); #1;
        fun = 3'b101; rs1 = 32'd1000; rs2 = 32'd3; d_valid = 1'b1;
        n = 0; guard = 0;
        while (n < 10 && guard < 100) begin
            @(negedge clk); #1; guard++;
            if (s_busy && s_stall) n++;
        end
        kill = 1'b1; d_valid = 1'b0;
        #1;
        chk("kill_stall", {31'd0, s_stall}, 32'd0);
        @(negedge clk); #1;
        kill = 1'b0;
        chk("kill_busy", {31'd0, s_busy}, 32'd0);
        chk("kill_rd",   s_rd,            32'd5);

        issue(3'b101, 32'd9, 32'd3, 32'd3, 34);                  // DIVU after kill
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);  // DIV overflow
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);          // REM overflow

        // hold stall in DONE for 5 cycles
        issue(3'b101, 32'h1234_5678, 32'h10, 32'h0123_4567, 34);
        hold = 1'b1;
        repeat (5) begin
            @(negedge clk); #1;
            chk("hold_rd",    s_rd,                 32'h0123_4567);
            chk("hold_state", {30'd0, s_busy, s_stall}, 32'd2);
        end
        hold = 1'b0;
        @(negedge clk); #1;
        chk("hold_exit", {31'd0, s_busy}, 32'd0);

        // back-to-back
        issue(3'b101, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34);
        issue(3'b101, 32'd10, 32'd3, 32'd3, 34);

        // reset mid-BUSY
        @(negedge clk); #1;
        fun = 3'b101; rs1 = 32'd100; rs2 = 32'd7; d_valid = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        d_valid = 1'b0; rst = 1'b1;
        @(negedge clk); #1;
        chk("rstmid_busy",  {31'd0, s_busy},  32'd0);
        chk("rstmid_stall", {31'd0, s_stall}, 32'd0);
        chk("rstmid_rd",    s_rd,             32'd0);
        rst = 1'b0;
        @(negedge clk); #1;

        // ---- radix-16 instance ----
        sel = 1'b1;
        #1;
        issue(3'b101, 32'd100, 32'd7, 32'd14, 10);
        issue(3'b111, 32'd100, 32'd7, 32'd2, 10);
        issue(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 10);
        issue(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 10);
        issue(3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);

        repeat (3) @(negedge clk);
        #1;
        chk("q1_drained", 32'(q1.size()), 32'd0);
        chk("q4_drained", 32'(q4.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
